beep_seq: RTL



---
 rtl/beep_pkg.sv | 53 +++++
 rtl/beep_seq_tone_gen.sv | 33 +++
 rtl/beep_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/beep_pkg.sv
// Shared types for the buzzer sequencer: notes, FSM states and the melody ROM.
package beep_pkg;

    typedef enum logic [2:0] {REST, LOW, C5, E5, G5, C6} note_e;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_e;

    localparam int FREQ_LOW = 262;
    localparam int FREQ_C5  = 523;
    localparam int FREQ_E5  = 659;
    localparam int FREQ_G5  = 784;
    localparam int FREQ_C6  = 1047;

    typedef struct packed {
        note_e      note;
        logic [2:0] units;
    } entry_t;

    typedef struct packed {
        entry_t entry;
        logic   last;
    } rom_t;

    // units == 0 marks an empty melody (mode 3)
    function automatic rom_t rom_lookup(input logic [1:0] mode, input logic [1:0] idx);
        rom_t r;
        r.entry.note  = REST;
        r.entry.units = 3'd0;
        r.last        = 1'b1;
        case (mode)
            2'd0: begin
                r.last = (idx == 2'd3);
                case (idx)
                    2'd0:    r.entry = '{C5, 3'd2};
                    2'd1:    r.entry = '{E5, 3'd2};
                    2'd2:    r.entry = '{G5, 3'd2};
                    default: r.entry = '{C6, 3'd4};
                endcase
            end
            2'd1: begin
                r.last = (idx >= 2'd2);
                case (idx)
                    2'd1:    r.entry = '{REST, 3'd1};
                    default: r.entry = '{LOW, 3'd4};
                endcase
            end
            2'd2: r.entry = '{C6, 3'd1};
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/beep_seq_tone_gen.sv
// Square-wave generator: toggles every i_half cycles, phase cleared on restart or disable.
module tone_gen #(
    parameter int HW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [HW-1:0] i_half,
    input  logic          i_en,
    input  logic          i_restart,
    output logic          o_wave
);

    logic [HW-1:0] r_phase;
    logic          r_wave;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_wave  <= 1'b0;
        end else if (!i_en || i_restart) begin
            r_phase <= '0;
            r_wave  <= 1'b0;
        end else if (r_phase == i_half - 1'b1) begin
            r_phase <= '0;
            r_wave  <= ~r_wave;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/beep_seq.sv
// Buzzer melody sequencer: st rising edge plays the melody chosen by mode, over pulses at the end.
// Optional BEEP_MUTE_EN adds a mute input that silences beep without changing timing.
module beep_seq
    import beep_pkg::*;
#(
    parameter int CLK_HZ  = 1000000,
    parameter int UNIT_MS = 100,
    parameter int GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       rst,
`ifdef BEEP_MUTE_EN
    input  logic       mute,
`endif
    input  logic       st,
    input  logic [1:0] mode,
    output logic       beep,
    output logic       busy,
    output logic       over
);

    localparam int UNIT_CYC = CLK_HZ / 1000 * UNIT_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int MAX_PLAY = 7 * UNIT_CYC;
    localparam int CNT_MAX  = (MAX_PLAY > GAP_CYC) ? MAX_PLAY : GAP_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam int HALF_LOW = CLK_HZ / (2 * FREQ_LOW);
    localparam int HALF_C5  = CLK_HZ / (2 * FREQ_C5);
    localparam int HALF_E5  = CLK_HZ / (2 * FREQ_E5);
    localparam int HALF_G5  = CLK_HZ / (2 * FREQ_G5);
    localparam int HALF_C6  = CLK_HZ / (2 * FREQ_C6);
    localparam int HW       = $clog2(HALF_LOW + 1);

    state_e           r_state;
    state_e           w_next;
    logic [1:0]       r_mode;
    logic [1:0]       r_idx;
    logic             r_st_d;
    logic [CNT_W-1:0] r_cnt;
    rom_t             w_rom;
    logic [CNT_W-1:0] w_play_len;
    logic [HW-1:0]    w_half;
    logic             w_wave;
    logic             w_start;

    assign w_rom      = rom_lookup(r_mode, r_idx);
    assign w_play_len = CNT_W'(UNIT_CYC) * CNT_W'(w_rom.entry.units);
    assign w_start    = st && !r_st_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        over   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start) w_next = LOAD;
            end
            LOAD: w_next = (w_rom.entry.units == 3'd0) ? DONE : PLAY;
            PLAY: if (r_cnt == w_play_len - 1'b1) w_next = w_rom.last ? DONE : GAP;
            GAP:  if (r_cnt == CNT_W'(GAP_CYC - 1)) w_next = PLAY;
            DONE: begin
                over   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // One shared counter times both PLAY and GAP; it is cleared on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st_d <= 1'b0;
            r_mode <= 2'd0;
            r_idx  <= 2'd0;
            r_cnt  <= '0;
        end else begin
            r_st_d <= st;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_mode <= mode;
                        r_idx  <= 2'd0;
                    end
                end
                LOAD: begin
                    r_idx <= 2'd0;
                    r_cnt <= '0;
                end
                PLAY: r_cnt <= (w_next != PLAY) ? '0 : r_cnt + 1'b1;
                GAP: begin
                    if (w_next != GAP) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_half = '0;
        case (w_rom.entry.note)
            LOW:     w_half = HW'(HALF_LOW);
            C5:      w_half = HW'(HALF_C5);
            E5:      w_half = HW'(HALF_E5);
            G5:      w_half = HW'(HALF_G5);
            C6:      w_half = HW'(HALF_C6);
            default: w_half = '0;
        endcase
    end

    tone_gen #(.HW(HW)) u_tone (
        .clk       (clk),
        .rst       (rst),
        .i_half    (w_half),
        .i_en      ((w_next == PLAY) && (w_rom.entry.note != REST)),
        .i_restart (r_state != PLAY),
        .o_wave    (w_wave)
    );

`ifdef BEEP_MUTE_EN
    assign beep = w_wave & ~mute;
`else
    assign beep = w_wave;
`endif

endmodule
